// File: rtl/cc_frame_loader.sv
// ---------------------------------------------------------------------------
// cc_frame_loader
//   Transmit side of the CC score-frame interface. Collects one SCORE_W-bit
//   student score per accepted beat (valid/ready) and, once NUM_STU beats
//   have arrived, presents them as one parallel frame to the ranking core.
//   Beat k becomes student k. The opt/a/b fields are taken from beat 0 only.
//
// Ports
//   clk, rst              single rising-edge clock, synchronous active-high reset
//   s_valid/s_ready       upstream beat handshake (s_ready is registered)
//   s_score, s_last       beat payload and end-of-frame marker
//   s_opt, s_a, s_b       frame options, sampled on beat 0
//   f_valid/f_ready       frame handshake towards the core (f_valid registered)
//   f_s0..f_s6            student scores 0..6
//   f_opt, f_a, f_b       frame options of the presented frame
//   err_short             1-cycle pulse: s_last before the final beat, frame dropped
//   err_long              1-cycle pulse: final beat without s_last, frame kept
//
// Build option
//   CC_FRAME_DBL_BUF_EN   adds a back buffer so the next frame can be collected
//                         while the current one is still being presented.
// ---------------------------------------------------------------------------
module cc_frame_loader #(
  parameter int NUM_STU = 7,
  parameter int SCORE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [SCORE_W-1:0] s_score,
  input  logic               s_last,
  input  logic [2:0]         s_opt,
  input  logic [1:0]         s_a,
  input  logic [2:0]         s_b,
  output logic               f_valid,
  input  logic               f_ready,
  output logic [SCORE_W-1:0] f_s0,
  output logic [SCORE_W-1:0] f_s1,
  output logic [SCORE_W-1:0] f_s2,
  output logic [SCORE_W-1:0] f_s3,
  output logic [SCORE_W-1:0] f_s4,
  output logic [SCORE_W-1:0] f_s5,
  output logic [SCORE_W-1:0] f_s6,
  output logic [2:0]         f_opt,
  output logic [1:0]         f_a,
  output logic [2:0]         f_b,
  output logic               err_short,
  output logic               err_long
);

  localparam int CNT_W = (NUM_STU > 1) ? $clog2(NUM_STU) : 1;
  localparam logic [CNT_W-1:0] LAST_K = CNT_W'(NUM_STU - 1);

  // ST_HOLD means the front buffer holds a frame that is offered to the core.
  typedef enum logic {ST_COLLECT, ST_HOLD} state_t;

  state_t             state;
  logic [CNT_W-1:0]   k;

  // Beats 0..NUM_STU-2 are staged here; the final beat goes straight to
  // whichever buffer loads, so a frame is complete on the accept itself.
  logic [SCORE_W-1:0] stage_s [NUM_STU-1];
  logic [2:0]         stage_opt;
  logic [1:0]         stage_a;
  logic [2:0]         stage_b;

  logic [SCORE_W-1:0] front_s [NUM_STU];
  logic [SCORE_W-1:0] new_s   [NUM_STU];

`ifdef CC_FRAME_DBL_BUF_EN
  logic [SCORE_W-1:0] back_s [NUM_STU];
  logic [2:0]         back_opt;
  logic [1:0]         back_a;
  logic [2:0]         back_b;
  logic               back_full;
  logic               back_full_nxt;
  logic               load_back;
  logic               load_front_back;
`endif

  logic accept;
  logic done;
  logic short_end;
  logic hs;
  logic load_front_new;
  logic f_valid_nxt;
  logic s_ready_nxt;

  assign accept    = s_valid & s_ready;
  assign done      = accept & (k == LAST_K);
  assign short_end = accept & s_last & (k != LAST_K);
  assign hs        = f_valid & f_ready;

  assign f_valid = (state == ST_HOLD);

  assign f_s0 = front_s[0];
  assign f_s1 = front_s[1];
  assign f_s2 = front_s[2];
  assign f_s3 = front_s[3];
  assign f_s4 = front_s[4];
  assign f_s5 = front_s[5];
  assign f_s6 = front_s[6];

  // The frame completed by this cycle's final beat: staged beats plus the
  // score currently on the bus.
  always_comb begin
    for (int i = 0; i < NUM_STU - 1; i++) begin
      new_s[i] = stage_s[i];
    end
    new_s[NUM_STU-1] = s_score;
  end

  // Buffer movement decisions. A completed frame goes to the front when the
  // front is empty or being consumed this same cycle; otherwise (double
  // buffer only) it parks in the back buffer. s_ready is precomputed here so
  // it can be registered: the loader refuses beats once there is no place
  // left to put the next completed frame.
  always_comb begin
    load_front_new = done & (~f_valid | hs);
`ifdef CC_FRAME_DBL_BUF_EN
    load_back       = done & f_valid & ~hs;
    load_front_back = hs & back_full;
    back_full_nxt   = load_back | (back_full & ~load_front_back);
    f_valid_nxt     = load_front_new | load_front_back | (f_valid & ~hs);
    s_ready_nxt     = ~back_full_nxt;
`else
    f_valid_nxt     = load_front_new | (f_valid & ~hs);
    s_ready_nxt     = ~f_valid_nxt;
`endif
  end

  // Beat counter, staging, buffer loads and registered handshake/error
  // outputs. A short frame just rewinds k; its staged beats are overwritten
  // by the next frame, and beat 0 of that frame re-latches opt/a/b.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_COLLECT;
      k         <= '0;
      s_ready   <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
      stage_opt <= '0;
      stage_a   <= '0;
      stage_b   <= '0;
      f_opt     <= '0;
      f_a       <= '0;
      f_b       <= '0;
      for (int i = 0; i < NUM_STU - 1; i++) begin
        stage_s[i] <= '0;
      end
      for (int i = 0; i < NUM_STU; i++) begin
        front_s[i] <= '0;
      end
`ifdef CC_FRAME_DBL_BUF_EN
      back_full <= 1'b0;
      back_opt  <= '0;
      back_a    <= '0;
      back_b    <= '0;
      for (int i = 0; i < NUM_STU; i++) begin
        back_s[i] <= '0;
      end
`endif
    end else begin
      err_short <= short_end;
      err_long  <= done & ~s_last;

      if (accept) begin
        if (done || s_last) begin
          k <= '0;
        end else begin
          k <= k + 1'b1;
        end
        if (k == '0) begin
          stage_opt <= s_opt;
          stage_a   <= s_a;
          stage_b   <= s_b;
        end
        if (k != LAST_K) begin
          stage_s[k] <= s_score;
        end
      end

      if (load_front_new) begin
        for (int i = 0; i < NUM_STU; i++) begin
          front_s[i] <= new_s[i];
        end
        f_opt <= stage_opt;
        f_a   <= stage_a;
        f_b   <= stage_b;
      end

`ifdef CC_FRAME_DBL_BUF_EN
      if (load_front_back) begin
        for (int i = 0; i < NUM_STU; i++) begin
          front_s[i] <= back_s[i];
        end
        f_opt <= back_opt;
        f_a   <= back_a;
        f_b   <= back_b;
      end
      if (load_back) begin
        for (int i = 0; i < NUM_STU; i++) begin
          back_s[i] <= new_s[i];
        end
        back_opt <= stage_opt;
        back_a   <= stage_a;
        back_b   <= stage_b;
      end
      back_full <= back_full_nxt;
`endif

      state   <= f_valid_nxt ? ST_HOLD : ST_COLLECT;
      s_ready <= s_ready_nxt;
    end
  end

endmodule

// File: tb/tb_cc_frame_loader.sv
// ---------------------------------------------------------------------------
// tb_cc_frame_loader
//   Self-checking bench for cc_frame_loader. A table of per-cycle vectors
//   (inputs plus the outputs expected after that clock edge) covers reset,
//   basic/short/long frames, backpressure and reset during a frame or hold.
//   Hand-written streaming sequences then check frame order and throughput,
//   and, when CC_FRAME_DBL_BUF_EN is defined, the double-buffer overlap.
// ---------------------------------------------------------------------------
module tb_cc_frame_loader;

`ifdef CC_FRAME_DBL_BUF_EN
  localparam logic DBL = 1'b1;
`else
  localparam logic DBL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       s_valid;
  logic       s_ready;
  logic [3:0] s_score;
  logic       s_last;
  logic [2:0] s_opt;
  logic [1:0] s_a;
  logic [2:0] s_b;
  logic       f_valid;
  logic       f_ready;
  logic [3:0] f_s0, f_s1, f_s2, f_s3, f_s4, f_s5, f_s6;
  logic [2:0] f_opt;
  logic [1:0] f_a;
  logic [2:0] f_b;
  logic       err_short;
  logic       err_long;

  always #5 clk = ~clk;

  cc_frame_loader dut (
    .clk       (clk),
    .rst       (rst),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_score   (s_score),
    .s_last    (s_last),
    .s_opt     (s_opt),
    .s_a       (s_a),
    .s_b       (s_b),
    .f_valid   (f_valid),
    .f_ready   (f_ready),
    .f_s0      (f_s0),
    .f_s1      (f_s1),
    .f_s2      (f_s2),
    .f_s3      (f_s3),
    .f_s4      (f_s4),
    .f_s5      (f_s5),
    .f_s6      (f_s6),
    .f_opt     (f_opt),
    .f_a       (f_a),
    .f_b       (f_b),
    .err_short (err_short),
    .err_long  (err_long)
  );

  // Frame image: {s6..s0, opt, a, b}.
  logic [35:0] act_frame;
  assign act_frame = {f_s6, f_s5, f_s4, f_s3, f_s2, f_s1, f_s0, f_opt, f_a, f_b};

  typedef struct packed {
    logic        rst;
    logic        valid;
    logic        last;
    logic        fready;
    logic [3:0]  score;
    logic [2:0]  opt;
    logic [1:0]  a;
    logic [2:0]  b;
    logic        e_ready;
    logic        e_fvalid;
    logic        e_short;
    logic        e_long;
    logic        chk;
    logic [35:0] frame;
  } vec_t;

  vec_t        tbl[$];
  logic [35:0] front_exp;
  int          checks   = 0;
  int          failures = 0;

  // Streaming state
  int beat_idx;
  int frames_sent;
  int frames_seen;
  int beats_acc;
  int cyc;
  int hs_cyc[$];

  task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic addRow(input logic rst_i, input logic valid_i, input logic [3:0] score_i,
                        input logic last_i, input logic [2:0] opt_i, input logic [1:0] a_i,
                        input logic [2:0] b_i, input logic fready_i, input logic er,
                        input logic ef, input logic es, input logic el, input logic ck,
                        input logic [35:0] fr);
    vec_t v;
    v.rst = rst_i; v.valid = valid_i; v.score = score_i; v.last = last_i;
    v.opt = opt_i; v.a = a_i; v.b = b_i; v.fready = fready_i;
    v.e_ready = er; v.e_fvalid = ef; v.e_short = es; v.e_long = el;
    v.chk = ck; v.frame = fr;
    tbl.push_back(v);
  endtask

  task automatic rstRow();
    front_exp = '0;
    addRow(1'b1, 1'b1, 4'h5, 1'b0, 3'h1, 2'h1, 3'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, front_exp);
  endtask

  task automatic idleRow(input logic fr, input logic er, input logic ef, input logic es, input logic el);
    addRow(1'b0, 1'b0, 4'h0, 1'b0, 3'h0, 2'h0, 3'h0, fr, er, ef, es, el, 1'b1, front_exp);
  endtask

  // Seven beats of one frame (sc holds s6..s0), with an optional idle
  // (s_valid=0) cycle inserted before beat gap_at. opt/a/b are driven with
  // junk on beats 1..6 so only beat 0 may be sampled. The front must keep its
  // previous contents until the final beat loads the new frame.
  task automatic addFrame(input logic [27:0] sc, input logic [2:0] o, input logic [1:0] a,
                          input logic [2:0] b, input logic last6, input logic fr, input int gap_at);
    for (int i = 0; i < 7; i++) begin
      if (i == gap_at) begin
        addRow(1'b0, 1'b0, 4'hF, 1'b0, 3'h7, 2'h3, 3'h7, fr, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, front_exp);
      end
      if (i < 6) begin
        addRow(1'b0, 1'b1, sc[i*4 +: 4], 1'b0, (i == 0) ? o : 3'h7, (i == 0) ? a : 2'h3,
               (i == 0) ? b : 3'h7, fr, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, front_exp);
      end else begin
        front_exp = {sc, o, a, b};
        addRow(1'b0, 1'b1, sc[27:24], last6, 3'h7, 2'h3, 3'h7, fr,
               DBL, 1'b1, 1'b0, ~last6, 1'b1, front_exp);
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst     = v.rst;
    s_valid = v.valid;
    s_score = v.score;
    s_last  = v.last;
    s_opt   = v.opt;
    s_a     = v.a;
    s_b     = v.b;
    f_ready = v.fready;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    checkVal($sformatf("row%0d s_ready", idx), 64'(s_ready), 64'(v.e_ready));
    checkVal($sformatf("row%0d f_valid", idx), 64'(f_valid), 64'(v.e_fvalid));
    checkVal($sformatf("row%0d err_short", idx), 64'(err_short), 64'(v.e_short));
    checkVal($sformatf("row%0d err_long", idx), 64'(err_long), 64'(v.e_long));
    if (v.chk) checkVal($sformatf("row%0d frame", idx), 64'(act_frame), 64'(v.frame));
  endtask

  // Streamed frame f: score of student i is (5f+3i+1) mod 16, opt=f+1, a=f, b=7-f.
  function automatic logic [35:0] expFrame(input int f);
    logic [35:0] r;
    for (int i = 0; i < 7; i++) r[8 + i*4 +: 4] = 4'((f*5 + i*3 + 1) % 16);
    r[7:5] = 3'((f + 1) % 8);
    r[4:3] = 2'(f % 4);
    r[2:0] = 3'(7 - (f % 8));
    return r;
  endfunction

  task automatic doReset();
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; f_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    beat_idx = 0; frames_sent = 0; frames_seen = 0; beats_acc = 0; cyc = 0;
    hs_cyc.delete();
  endtask

  // One streaming cycle: drive the current beat, check any frame handshaked
  // at the coming edge against the model, then advance the beat position if
  // the beat was accepted.
  task automatic streamCycle(input logic fr, input logic sv);
    logic [35:0] ef;
    logic        acc;
    logic        hs;
    ef      = expFrame(frames_sent);
    f_ready = fr;
    s_valid = sv;
    s_score = ef[8 + beat_idx*4 +: 4];
    s_last  = (beat_idx == 6);
    s_opt   = (beat_idx == 0) ? ef[7:5] : ~ef[7:5];
    s_a     = (beat_idx == 0) ? ef[4:3] : ~ef[4:3];
    s_b     = (beat_idx == 0) ? ef[2:0] : ~ef[2:0];
    acc     = sv & s_ready;
    hs      = f_valid & fr;
    if (hs) begin
      checkVal($sformatf("stream frame%0d", frames_seen), 64'(act_frame), 64'(expFrame(frames_seen)));
      frames_seen++;
      hs_cyc.push_back(cyc);
    end
    @(posedge clk); #1;
    cyc++;
    if (acc) begin
      beats_acc++;
      if (beat_idx == 6) begin
        beat_idx = 0;
        frames_sent++;
      end else begin
        beat_idx++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p1;
    int p2;
    int guard;
    rst = 1'b1; s_valid = 1'b1; s_score = '0; s_last = 1'b0;
    s_opt = '0; s_a = '0; s_b = '0; f_ready = 1'b0;
    front_exp = '0;

    // Reset held 3 cycles with s_valid=1, then release.
    rstRow(); rstRow(); rstRow();
    idleRow(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // Basic frame 3,9,0,15,7,1,12 opt=5 a=2 b=4, consumed at once.
    addFrame(28'hC17F093, 3'h5, 2'h2, 3'h4, 1'b1, 1'b1, -1);
    idleRow(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // Short frame: s_last on beat 3.
    addRow(1'b0, 1'b1, 4'h8, 1'b0, 3'h7, 2'h3, 3'h7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, front_exp);
    addRow(1'b0, 1'b1, 4'h8, 1'b0, 3'h7, 2'h3, 3'h7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, front_exp);
    addRow(1'b0, 1'b1, 4'h8, 1'b0, 3'h7, 2'h3, 3'h7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, front_exp);
    addRow(1'b0, 1'b1, 4'h8, 1'b1, 3'h7, 2'h3, 3'h7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, front_exp);
    idleRow(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // All-8 frame with its own opt, then held for 10 cycles of backpressure.
    addFrame(28'h8888888, 3'h2, 2'h1, 3'h2, 1'b1, 1'b0, -1);
    for (int i = 0; i < 10; i++)
      addRow(1'b0, ~DBL, 4'hF, 1'b0, 3'h7, 2'h3, 3'h7, 1'b0, DBL, 1'b1, 1'b0, 1'b0, 1'b1, front_exp);
    idleRow(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // Long frame (no s_last) with an s_valid gap before beat 3.
    addFrame(28'h7654321, 3'h3, 2'h0, 3'h1, 1'b0, 1'b1, 3);
    idleRow(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    // Reset while a frame is held.
    addFrame(28'h0123456, 3'h1, 2'h1, 3'h1, 1'b1, 1'b0, -1);
    rstRow();
    idleRow(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    // Reset mid-frame, then a full frame must start from beat 0.
    for (int i = 0; i < 3; i++)
      addRow(1'b0, 1'b1, 4'h9, 1'b0, 3'h4, 2'h1, 3'h1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, front_exp);
    rstRow();
    idleRow(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    addFrame(28'h2222222, 3'h6, 2'h3, 3'h5, 1'b1, 1'b1, -1);
    idleRow(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("[TB] applying %0d table vectors", tbl.size());
    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      @(posedge clk); #1;
      checkOutput(tbl[i], i);
    end

    // Continuous stream of 3 frames, consumer always ready.
    $display("[TB] streaming throughput sequence");
    doReset();
    while (frames_seen < 3 && cyc < 100) streamCycle(1'b1, frames_sent < 3);
    checkVal("stream frames_seen", 64'(frames_seen), 64'd3);
    checkVal("stream hs_count", 64'(hs_cyc.size()), 64'd3);
    p1 = (hs_cyc.size() >= 2) ? hs_cyc[1] - hs_cyc[0] : -1;
    p2 = (hs_cyc.size() >= 3) ? hs_cyc[2] - hs_cyc[1] : -1;
    checkVal("frame_period_1", 64'(p1), DBL ? 64'd7 : 64'd8);
    checkVal("frame_period_2", 64'(p2), DBL ? 64'd7 : 64'd8);

`ifdef CC_FRAME_DBL_BUF_EN
    // Three back-to-back frames with the consumer stalled: two fit, then
    // s_ready drops; on release the buffered frames leave without a gap.
    $display("[TB] double-buffer overlap sequence");
    doReset();
    streamCycle(1'b0, 1'b1);
    guard = 0;
    while (s_ready && guard < 40) begin
      streamCycle(1'b0, frames_sent < 3);
      guard++;
    end
    checkVal("dbl stall beats", 64'(beats_acc), 64'd14);
    checkVal("dbl stall s_ready", 64'(s_ready), 64'd0);
    checkVal("dbl stall f_valid", 64'(f_valid), 64'd1);
    streamCycle(1'b1, frames_sent < 3);
    checkVal("dbl no_gap f_valid", 64'(f_valid), 64'd1);
    checkVal("dbl reopen s_ready", 64'(s_ready), 64'd1);
    guard = 0;
    while (frames_seen < 3 && guard < 60) begin
      streamCycle(1'b1, frames_sent < 3);
      guard++;
    end
    checkVal("dbl frames_seen", 64'(frames_seen), 64'd3);
`else
    guard = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
